// File: rtl/bit_mux.sv
// Parameterised 1-of-N bit selector with a combinational output and an
// enable-gated registered copy plus an out-of-range select flag.
module bit_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [SEL_WIDTH-1:0]  S,
    input  logic                  en,
    output logic                  Y,
    output logic                  Y_r,
    output logic                  sel_err
);

    // One extra bit so the limit still fits when DATA_WIDTH is a power of two.
    localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH + 1)'(DATA_WIDTH);

    logic [SEL_WIDTH:0] s_ext;
    logic               in_range;
    logic               y_c;

    assign s_ext    = {1'b0, S};
    assign in_range = (s_ext < SEL_LIMIT);

    // Only the bit whose index matches S is ever read, so X on unselected
    // inputs cannot reach Y; an out-of-range S matches nothing and yields 0.
    always_comb begin
        y_c = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (S == SEL_WIDTH'(i)) begin
                y_c = D[i];
            end
        end
    end

    assign Y = y_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_r     <= 1'b0;
            sel_err <= 1'b0;
        end else if (en) begin
            Y_r     <= y_c;
            sel_err <= ~in_range;
        end
    end

endmodule

// File: tb/tb_bit_mux.sv
// Directed and random checks of bit_mux at widths 2, 3, 5, 8 and 16, with
// registered results tracked through an expected queue.
module tb_bit_mux;

    logic clk;
    logic rst_n;

    logic [1:0]  d2;  logic       s2;  logic en2;  logic y2,  yr2,  er2;
    logic [2:0]  d3;  logic [1:0] s3;  logic en3;  logic y3,  yr3,  er3;
    logic [4:0]  d5;  logic [2:0] s5;  logic en5;  logic y5,  yr5,  er5;
    logic [7:0]  d8;  logic [2:0] s8;  logic en8;  logic y8,  yr8,  er8;
    logic [15:0] d16; logic [3:0] s16; logic en16; logic y16, yr16, er16;

    int n_vec;
    int n_err;
    logic [7:0] exp_q[$];

    bit_mux #(.DATA_WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .D(d2),  .S(s2),  .en(en2),  .Y(y2),  .Y_r(yr2),  .sel_err(er2));
    bit_mux #(.DATA_WIDTH(3))  dut3  (.clk(clk), .rst_n(rst_n), .D(d3),  .S(s3),  .en(en3),  .Y(y3),  .Y_r(yr3),  .sel_err(er3));
    bit_mux #(.DATA_WIDTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .D(d5),  .S(s5),  .en(en5),  .Y(y5),  .Y_r(yr5),  .sel_err(er5));
    bit_mux                    dut8  (.clk(clk), .rst_n(rst_n), .D(d8),  .S(s8),  .en(en8),  .Y(y8),  .Y_r(yr8),  .sel_err(er8));
    bit_mux #(.DATA_WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .D(d16), .S(s16), .en(en16), .Y(y16), .Y_r(yr16), .sel_err(er16));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_mux(input logic [15:0] d, input int s, input int w);
        if (s < w) return d[s];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : stim
        logic [7:0] e;
        logic       r2, r3, r8, r16, re3, en_all;
        logic       m2, m3, m8, m16, me3;
        logic [7:0] one_hot;
        logic [6:0] cnt_hot;
        n_vec = 0;
        n_err = 0;

        rst_n = 1'b0;
        d2 = '0; s2 = '0; en2 = 1'b0;
        d3 = '0; s3 = '0; en3 = 1'b0;
        d5 = '0; s5 = '0; en5 = 1'b0;
        d8 = '0; s8 = '0; en8 = 1'b0;
        d16 = '0; s16 = '0; en16 = 1'b0;

        // reset state, and Y still follows D/S while in reset
        tick();
        chk("rst_yr8", yr8, 1'b0);
        chk("rst_er8", er8, 1'b0);
        chk("rst_yr5", yr5, 1'b0);
        chk("rst_er5", er5, 1'b0);
        d8 = 8'h10; s8 = 3'd4; #1;
        chk("rst_y8_follows", y8, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // walking one / walking zero on the 8-bit instance
        for (int s = 0; s < 8; s++) begin
            one_hot = 8'(1 << s);
            s8 = 3'(s);
            d8 = one_hot; #1;
            chk($sformatf("walk1_s%0d", s), y8, 1'b1);
            d8 = ~one_hot; #1;
            chk($sformatf("walk0_s%0d", s), y8, 1'b0);
        end

        // 2-bit instance driven from a counter
        for (int c = 0; c < 7; c++) begin
            cnt_hot = 7'(1 << c);
            s2 = cnt_hot[0] | (c[0] == 1'b1);
            s2 = c[0];
            d2 = cnt_hot[1:0]; #1;
            chk($sformatf("cnt2_c%0d", c), y2, (c < 2) ? 1'b1 : 1'b0);
        end

        // capture, then hold with en low
        @(negedge clk);
        d8 = 8'hA5; s8 = 3'd2; en8 = 1'b1; #1;
        chk("a5_s2_y", y8, 1'b1);
        exp_q.push_back(8'b0000_0001);
        tick();
        e = exp_q.pop_front();
        chk("a5_s2_yr", yr8, e[0]);
        chk("a5_s2_er", er8, e[1]);
        en8 = 1'b0; s8 = 3'd1; #1;
        chk("a5_s1_y", y8, 1'b0);
        tick();
        chk("a5_hold_yr", yr8, 1'b1);

        // out-of-range select on the 5-bit instance
        d5 = 5'h1F; s5 = 3'd6; en5 = 1'b1; #1;
        chk("w5_s6_y", y5, 1'b0);
        exp_q.push_back(8'b0000_0010);
        tick();
        e = exp_q.pop_front();
        chk("w5_s6_yr", yr5, e[0]);
        chk("w5_s6_er", er5, e[1]);
        s5 = 3'd5; #1;
        chk("w5_s5_y", y5, 1'b0);
        s5 = 3'd4; #1;
        chk("w5_s4_y", y5, 1'b1);
        exp_q.push_back(8'b0000_0001);
        tick();
        e = exp_q.pop_front();
        chk("w5_s4_yr", yr5, e[0]);
        chk("w5_s4_er", er5, e[1]);
        s5 = 3'd7; #1;
        tick();
        chk("w5_s7_er", er5, 1'b1);
        en5 = 1'b0;

        // asynchronous reset between edges; Y keeps following D/S
        s8 = 3'd0; #2;
        chk("pre_arst_yr8", yr8, 1'b1);
        rst_n = 1'b0; #1;
        chk("arst_yr8", yr8, 1'b0);
        chk("arst_er5", er5, 1'b0);
        chk("arst_y8", y8, 1'b1);
        d8 = 8'hFF; s8 = 3'd3; en8 = 1'b1;
        @(posedge clk); #1;
        chk("arst_abort_yr8", yr8, 1'b0);
        chk("arst_y8_ff", y8, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_cap_yr8", yr8, 1'b1);
        en8 = 1'b0;

        // random vectors on widths 2, 3, 8, 16
        rst_n = 1'b0; #1;
        rst_n = 1'b1;
        m2 = 1'b0; m3 = 1'b0; m8 = 1'b0; m16 = 1'b0; me3 = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            d2  = 2'($urandom_range(0, 3));     s2  = 1'($urandom_range(0, 1));
            d3  = 3'($urandom_range(0, 7));     s3  = 2'($urandom_range(0, 3));
            d8  = 8'($urandom_range(0, 255));   s8  = 3'($urandom_range(0, 7));
            d16 = 16'($urandom_range(0, 65535)); s16 = 4'($urandom_range(0, 15));
            en_all = ($urandom_range(0, 3) != 0);
            en2 = en_all; en3 = en_all; en8 = en_all; en16 = en_all;
            r2  = ref_mux(16'(d2), int'(s2), 2);
            r3  = ref_mux(16'(d3), int'(s3), 3);
            r8  = ref_mux(16'(d8), int'(s8), 8);
            r16 = ref_mux(d16, int'(s16), 16);
            re3 = (int'(s3) >= 3);
            #1;
            chk("rnd_y2", y2, r2);
            chk("rnd_y3", y3, r3);
            chk("rnd_y8", y8, r8);
            chk("rnd_y16", y16, r16);
            if (en_all) exp_q.push_back({3'b000, re3, r16, r8, r3, r2});
            @(posedge clk);
            @(negedge clk);
            if (en_all) begin
                e = exp_q.pop_front();
                m2 = e[0]; m3 = e[1]; m8 = e[2]; m16 = e[3]; me3 = e[4];
            end
            chk("rnd_yr2", yr2, m2);
            chk("rnd_yr3", yr3, m3);
            chk("rnd_yr8", yr8, m8);
            chk("rnd_yr16", yr16, m16);
            chk("rnd_er3", er3, me3);
            chk("rnd_er16", er16, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
